inert_ptch_intf: RTL
====================

# inert_ptch_intf

Producer side of the pitch interface consumed by the balance PID: commands the IMU over an existing SPI master (wrt/done handshake), reads pitch rate and Z-axis acceleration on every data-ready interrupt, fuses them into a signed pitch estimate, and presents ptch, ptch_rt, and a one-cycle vld strobe. It sits between the SPI master and the PID/balance controller.

## Interface
- FAST_SIM, 1, shortens the IMU power-up wait from 65536 to 1024 clocks.
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- INT  in  1  IMU data-ready; asynchronous level, double-flopped internally
- wrt  out  1  one-cycle SPI transaction request
- cmd  out  16  SPI command word; stable from the wrt cycle until done
- done  in  1  one-cycle SPI completion pulse; rd_data valid in the same cycle
- rd_data  in  16  SPI read data; only [7:0] used
- ptch  out  16  signed fused pitch
- ptch_rt  out  16  signed offset-compensated pitch rate
- vld  out  1  one-cycle strobe; ptch and ptch_rt hold new values during it

## Operation
- Reset values: wrt 0, cmd 0, ptch 0, ptch_rt 0, vld 0, integrator 0, FSM in INIT_WAIT, timer 0.
- FSM states:
  - INIT_WAIT: a 16-bit timer increments. Terminal count is &tmr[15:0], or &tmr[9:0] when FAST_SIM=1.
  - CFG0..CFG3: write 0x0D02, 0x1053, 0x1150, 0x1460 in that order.
  - IDLE: wait for INT.
  - RD0..RD3: read 0xA200 (rate L), 0xA300 (rate H), 0xAC00 (AZ L), 0xAD00 (AZ H).
  - UPD: integrator update.
- Each CFG/RD state issues one wrt pulse on entry, then waits for done. The next state's wrt occurs no earlier than the cycle after done.
- IDLE → RD0 when synchronized INT is 1. INT is ignored in every other state, so there is exactly one 4-read burst per entry to IDLE.
- On each read done, capture rd_data[7:0] into the matching byte register: rate_L, rate_H, AZ_L, AZ_H.
- UPD lasts one cycle, then returns to IDLE.
- Arithmetic (all signed):
  - rate_comp = {rate_H,rate_L} − 16'h0050
  - AZ_comp = {AZ_H,AZ_L} − 16'h00A0
  - ptch_acc_prod (26b) = AZ_comp × 327
  - ptch_acc = sign-extended ptch_acc_prod[25:13]
- Integrator (27-bit signed), in UPD: ptch_int ← ptch_int − sext(rate_comp) + fusion.
  - fusion = +1024 if ptch_acc > current ptch.
  - fusion = −1024 if ptch_acc < current ptch.
  - fusion = 0 if they are equal.
- No saturation; the integrator wraps at 27 bits.
- ptch = ptch_int[26:11]. ptch_rt register = rate_comp, loaded in UPD.
- Reset mid-transaction aborts everything: all state and outputs go to reset values and the init sequence restarts at INIT_WAIT. A late done arriving after reset is ignored outside the waiting states.
- done arriving while in IDLE or INIT_WAIT is ignored.

## Timing
- INT input to the synchronized level takes 2 clk; wrt for 0xA200 follows 1 clk later.
- UPD edge to vld: vld asserts 1 clk after the UPD edge, for exactly one cycle.
  - ptch and ptch_rt change only on the UPD edge, so they are already updated when vld=1.
  - They then hold until the next UPD.
- Last done to vld = 2 clk.
- Minimum spacing between vld pulses = 4 SPI transactions + 3 clk.

## Structure
- Package inert_pkg holds:
  - the state enum;
  - CFG command constants (0x0D02, 0x1053, 0x1150, 0x1460);
  - read command constants (0xA200, 0xA300, 0xAC00, 0xAD00);
  - RATE_OFFSET 16'h0050 and AZ_OFFSET 16'h00A0;
  - ACC_GAIN 327 and FUSION_STEP 1024.
- Sub-module ptch_fusion contains the arithmetic, integrator, ptch/ptch_rt registers, and vld delay. Its inputs are the four bytes and the update strobe.
- The parent keeps the FSM, INT synchronizer, power-up timer, and SPI handshake.

## Test plan
- Init sequence:
  - Stimulus: FAST_SIM=1, release reset; the SPI model returns done 20 clk after each wrt.
  - Required: first wrt at clock 1024, cmd 0x0D02, then 0x1053, 0x1150, 0x1460; no further wrt until INT.
- Zero input:
  - Stimulus: INT high; rd_data bytes 0x50, 0x00, 0xA0, 0x00.
  - Required: cmd order 0xA200/0xA300/0xAC00/0xAD00; vld one cycle, 2 clk after the 4th done; ptch=0, ptch_rt=0.
- Constant rate:
  - Stimulus: bytes 0x50, 0x40, 0xA0, 0x00 (rate_comp=0x4000) on 8 consecutive INTs.
  - Required: ptch_rt=0x4000; after the 1st vld ptch=0xFFF8 (−8); after the 8th vld ptch=0xFFC3 (−61).
- INT held high throughout a burst:
  - Stimulus: hold INT high during a read burst.
  - Required: exactly 4 wrt per burst; a new burst begins only after returning to IDLE; wrt is never asserted while a done is outstanding.
- Reset mid-read:
  - Stimulus: drop rst_n while waiting for done in RD2.
  - Required: wrt, cmd, ptch, ptch_rt, vld all 0; a stray done is ignored; the CFG sequence reissues after the timer expires.
- Accel fusion:
  - Stimulus: rate bytes 0x50, 0x00; AZ bytes 0xA0, 0x10 (AZ_comp=0x1000).
  - Required: ptch_acc=163; each vld adds +1024 to ptch_int; ptch reaches 1 after 2 vld pulses.

Source files
------------

// File: rtl/inert_pkg.sv
// Shared types and constants for the IMU pitch interface: FSM states, SPI
// command words, sensor offsets and fusion gains.
package inert_pkg;

    localparam int unsigned CMD_W      = 16;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned TMR_W      = 16;
    localparam int unsigned FAST_TMR_W = 10;
    localparam int unsigned INT_W      = 27;
    localparam int unsigned PROD_W     = 26;
    localparam int unsigned ACC_W      = 13;

    typedef enum logic [3:0] {
        INIT_WAIT,
        CFG0, CFG1, CFG2, CFG3,
        IDLE,
        RD0, RD1, RD2, RD3,
        UPD
    } state_t;

    localparam logic [CMD_W-1:0] CFG_CMD0 = 16'h0D02;
    localparam logic [CMD_W-1:0] CFG_CMD1 = 16'h1053;
    localparam logic [CMD_W-1:0] CFG_CMD2 = 16'h1150;
    localparam logic [CMD_W-1:0] CFG_CMD3 = 16'h1460;

    localparam logic [CMD_W-1:0] RD_RATE_L = 16'hA200;
    localparam logic [CMD_W-1:0] RD_RATE_H = 16'hA300;
    localparam logic [CMD_W-1:0] RD_AZ_L   = 16'hAC00;
    localparam logic [CMD_W-1:0] RD_AZ_H   = 16'hAD00;

    localparam logic [CMD_W-1:0] RATE_OFFSET = 16'h0050;
    localparam logic [CMD_W-1:0] AZ_OFFSET   = 16'h00A0;

    localparam int ACC_GAIN    = 327;
    localparam int FUSION_STEP = 1024;

    // Raw sensor bytes gathered over one read burst
    typedef struct packed {
        logic [BYTE_W-1:0] rate_h;
        logic [BYTE_W-1:0] rate_l;
        logic [BYTE_W-1:0] az_h;
        logic [BYTE_W-1:0] az_l;
    } imu_bytes_t;

    function automatic logic [CMD_W-1:0] cmd_for_state(input state_t s);
        logic [CMD_W-1:0] c;
        c = '0;
        case (s)
            CFG0:    c = CFG_CMD0;
            CFG1:    c = CFG_CMD1;
            CFG2:    c = CFG_CMD2;
            CFG3:    c = CFG_CMD3;
            RD0:     c = RD_RATE_L;
            RD1:     c = RD_RATE_H;
            RD2:     c = RD_AZ_L;
            RD3:     c = RD_AZ_H;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic is_spi_state(input state_t s);
        return (s inside {CFG0, CFG1, CFG2, CFG3, RD0, RD1, RD2, RD3});
    endfunction

endpackage

// File: rtl/inert_ptch_intf_if.sv
// SPI handshake plus pitch result bus; master is the pitch producer side.
interface inert_ptch_intf_if;
    import inert_pkg::*;

    logic             wrt;
    logic [CMD_W-1:0] cmd;
    logic             done;
    logic [CMD_W-1:0] rd_data;
    logic [CMD_W-1:0] ptch;
    logic [CMD_W-1:0] ptch_rt;
    logic             vld;

    modport master (
        output wrt, cmd, ptch, ptch_rt, vld,
        input  done, rd_data
    );

    modport slave (
        input  wrt, cmd, ptch, ptch_rt, vld,
        output done, rd_data
    );

endinterface

// File: rtl/ptch_fusion.sv
// Offset compensation, accel/gyro complementary fusion and the pitch
// integrator; publishes ptch/ptch_rt on the update strobe with a delayed vld.
module ptch_fusion
    import inert_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  imu_bytes_t       i_bytes,
    input  logic             i_upd,
    output logic [CMD_W-1:0] o_ptch,
    output logic [CMD_W-1:0] o_ptch_rt,
    output logic             o_vld
);

    localparam logic signed [PROD_W-1:0] GAIN = PROD_W'(ACC_GAIN);
    localparam logic signed [INT_W-1:0]  STEP = INT_W'(FUSION_STEP);

    logic signed [INT_W-1:0]  r_ptch_int;
    logic signed [CMD_W-1:0]  r_ptch_rt;
    logic                     r_vld;

    logic signed [CMD_W-1:0]  w_rate_comp;
    logic signed [CMD_W-1:0]  w_az_comp;
    logic signed [PROD_W-1:0] w_acc_prod;
    logic signed [CMD_W-1:0]  w_ptch_acc;
    logic signed [CMD_W-1:0]  w_ptch_cur;
    logic signed [INT_W-1:0]  w_fusion;
    logic signed [INT_W-1:0]  w_int_nxt;

    // Pitch from gravity is AZ scaled and truncated to 13 significant bits
    always_comb begin
        w_rate_comp = {i_bytes.rate_h, i_bytes.rate_l} - RATE_OFFSET;
        w_az_comp   = {i_bytes.az_h, i_bytes.az_l} - AZ_OFFSET;
        w_acc_prod  = PROD_W'(w_az_comp) * GAIN;
        w_ptch_acc  = {{(CMD_W-ACC_W){w_acc_prod[PROD_W-1]}}, w_acc_prod[PROD_W-1 -: ACC_W]};
        w_ptch_cur  = r_ptch_int[INT_W-1 -: CMD_W];
        w_fusion    = '0;
        if (w_ptch_acc > w_ptch_cur) begin
            w_fusion = STEP;
        end else if (w_ptch_acc < w_ptch_cur) begin
            w_fusion = -STEP;
        end
        w_int_nxt = r_ptch_int - INT_W'(w_rate_comp) + w_fusion;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptch_int <= '0;
            r_ptch_rt  <= '0;
            r_vld      <= 1'b0;
        end else begin
            r_vld <= i_upd;
            if (i_upd) begin
                r_ptch_int <= w_int_nxt;
                r_ptch_rt  <= w_rate_comp;
            end
        end
    end

    assign o_ptch    = r_ptch_int[INT_W-1 -: CMD_W];
    assign o_ptch_rt = r_ptch_rt;
    assign o_vld     = r_vld;

endmodule

// File: rtl/inert_ptch_intf.sv
// IMU pitch producer: power-up wait, IMU configuration, one 4-byte read burst
// per data-ready, then hands the bytes to the fusion datapath.
module inert_ptch_intf
    import inert_pkg::*;
#(
    parameter bit FAST_SIM = 1'b1
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               INT,
    inert_ptch_intf_if.master  bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_int_ff1;
    logic             r_int_sync;
    logic [TMR_W-1:0] r_tmr;
    logic [TMR_W-1:0] w_tmr_nxt;
    logic             r_wrt;
    logic             w_wrt_nxt;
    logic [CMD_W-1:0] r_cmd;
    logic [CMD_W-1:0] w_cmd_nxt;
    imu_bytes_t       r_bytes;
    imu_bytes_t       w_bytes_nxt;
    logic             w_tmr_done;
    logic             w_upd;
    logic [CMD_W-1:0] w_ptch;
    logic [CMD_W-1:0] w_ptch_rt;
    logic             w_vld;
    logic             w_unused_hi;

    assign w_unused_hi = ^bus.rd_data[CMD_W-1:BYTE_W];
    assign w_tmr_done  = FAST_SIM ? (&r_tmr[FAST_TMR_W-1:0]) : (&r_tmr);
    assign w_upd       = (r_state == UPD);

    // Data-ready is asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_ff1  <= 1'b0;
            r_int_sync <= 1'b0;
        end else begin
            r_int_ff1  <= INT;
            r_int_sync <= r_int_ff1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT_WAIT;
            r_tmr   <= '0;
            r_wrt   <= 1'b0;
            r_cmd   <= '0;
            r_bytes <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_wrt   <= w_wrt_nxt;
            r_cmd   <= w_cmd_nxt;
            r_bytes <= w_bytes_nxt;
        end
    end

    // done only advances the CFG/RD states; elsewhere it is ignored
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = '0;
        w_wrt_nxt   = 1'b0;
        w_cmd_nxt   = r_cmd;
        w_bytes_nxt = r_bytes;
        case (r_state)
            INIT_WAIT: begin
                w_tmr_nxt = r_tmr + TMR_W'(1);
                if (w_tmr_done) w_state_nxt = CFG0;
            end
            CFG0: if (bus.done) w_state_nxt = CFG1;
            CFG1: if (bus.done) w_state_nxt = CFG2;
            CFG2: if (bus.done) w_state_nxt = CFG3;
            CFG3: if (bus.done) w_state_nxt = IDLE;
            IDLE: if (r_int_sync) w_state_nxt = RD0;
            RD0: if (bus.done) begin
                w_bytes_nxt.rate_l = bus.rd_data[BYTE_W-1:0];
                w_state_nxt        = RD1;
            end
            RD1: if (bus.done) begin
                w_bytes_nxt.rate_h = bus.rd_data[BYTE_W-1:0];
                w_state_nxt        = RD2;
            end
            RD2: if (bus.done) begin
                w_bytes_nxt.az_l = bus.rd_data[BYTE_W-1:0];
                w_state_nxt      = RD3;
            end
            RD3: if (bus.done) begin
                w_bytes_nxt.az_h = bus.rd_data[BYTE_W-1:0];
                w_state_nxt      = UPD;
            end
            UPD:     w_state_nxt = IDLE;
            default: w_state_nxt = INIT_WAIT;
        endcase
        // One request on entry to each SPI state; cmd then holds until next entry
        if ((w_state_nxt != r_state) && is_spi_state(w_state_nxt)) begin
            w_wrt_nxt = 1'b1;
            w_cmd_nxt = cmd_for_state(w_state_nxt);
        end
    end

    ptch_fusion u_fusion (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_bytes   (r_bytes),
        .i_upd     (w_upd),
        .o_ptch    (w_ptch),
        .o_ptch_rt (w_ptch_rt),
        .o_vld     (w_vld)
    );

    assign bus.wrt     = r_wrt;
    assign bus.cmd     = r_cmd;
    assign bus.ptch    = w_ptch;
    assign bus.ptch_rt = w_ptch_rt;
    assign bus.vld     = w_vld;

endmodule
